gas_dispense_ctrl: RTL and testbench



---
 rtl/gas_pump_pkg.sv | 28 ++
 rtl/flow_meter_counter.sv | 28 ++
 rtl/gas_dispense_ctrl.sv | 158 +++++++++++++++
 tb/tb_gas_dispense_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gas_pump_pkg.sv
// Shared types and widths for the fuel dispense controller.
package gas_pump_pkg;

  localparam int LITER_W = 8;
  localparam int COST_W  = 16;
  localparam int TIMER_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DISPENSE,
    ST_PAUSE,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    END_FULL    = 2'd0,
    END_HANGUP  = 2'd1,
    END_TIMEOUT = 2'd2,
    END_ZERO    = 2'd3
  } end_code_t;

  typedef struct packed {
    state_t     state;
    logic [7:0] pulse_cnt;
  } debug_t;

endpackage

// File: rtl/flow_meter_counter.sv
// Counts meter pulses and emits a combinational tick on the pulse that
// completes a whole litre, wrapping the pulse count back to zero.
module flow_meter_counter #(
  parameter  int PULSES_PER_LITER = 10,
  localparam int CNT_W            = $clog2(PULSES_PER_LITER)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             pulse,
  input  logic             clr,
  output logic             litre_tick,
  output logic [CNT_W-1:0] pulse_cnt
);

  assign litre_tick = en && pulse && (pulse_cnt == CNT_W'(PULSES_PER_LITER - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_cnt <= '0;
    end else if (clr) begin
      pulse_cnt <= '0;
    end else if (en && pulse) begin
      pulse_cnt <= litre_tick ? '0 : pulse_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gas_dispense_ctrl.sv
// Runs one authorised fuel sale: waits for nozzle lift, drives pump/valve,
// meters litres, accumulates the charge and reports how the sale ended.
module gas_dispense_ctrl
  import gas_pump_pkg::*;
#(
  parameter int PULSES_PER_LITER = 10,
  parameter int TIMEOUT_CYCLES   = 1000,
  parameter int PAUSE_CYCLES     = 500
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               auth_valid,
  input  logic [LITER_W-1:0] auth_liters,
  input  logic [7:0]         auth_price,
  output logic               auth_ready,
  input  logic               nozzle_lifted,
  input  logic               trigger,
  input  logic               flow_pulse,
  output logic               pump_en,
  output logic               valve_open,
  output logic [LITER_W-1:0] liters_dispensed,
  output logic [COST_W-1:0]  amount_charged,
  output logic               busy,
  output logic               dispense_done,
  output logic [1:0]         end_code,
  output debug_t             debug
);

  localparam int CNT_W = $clog2(PULSES_PER_LITER);

  state_t               state, state_next;
  end_code_t            end_reg, end_next;
  logic [LITER_W-1:0]   target, liters;
  logic [7:0]           price;
  logic [COST_W-1:0]    amount;
  logic [TIMER_W-1:0]   timer;
  logic [CNT_W-1:0]     pulse_cnt;
  logic                 accept, litre_tick, reach_target;

  assign accept       = (state == ST_IDLE) && auth_valid;
  assign reach_target = litre_tick && (({1'b0, liters} + 9'd1) == {1'b0, target});

  flow_meter_counter #(.PULSES_PER_LITER(PULSES_PER_LITER)) u_meter (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (state == ST_DISPENSE),
    .pulse      (flow_pulse),
    .clr        (accept),
    .litre_tick (litre_tick),
    .pulse_cnt  (pulse_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Same-cycle priority in DISPENSE: target reached, then hang-up, then release.
  always_comb begin
    state_next = state;
    end_next   = end_reg;
    case (state)
      ST_IDLE: begin
        if (auth_valid) begin
          if (auth_liters == '0) begin
            state_next = ST_FINISH;
            end_next   = END_ZERO;
          end else begin
            state_next = ST_ARMED;
            end_next   = END_FULL;
          end
        end
      end
      ST_ARMED: begin
        if (nozzle_lifted && trigger) begin
          state_next = ST_DISPENSE;
        end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          state_next = ST_FINISH;
          end_next   = END_TIMEOUT;
        end
      end
      ST_DISPENSE: begin
        if (reach_target) begin
          state_next = ST_FINISH;
          end_next   = END_FULL;
        end else if (!nozzle_lifted) begin
          state_next = ST_FINISH;
          end_next   = END_HANGUP;
        end else if (!trigger) begin
          state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (!nozzle_lifted || (timer == TIMER_W'(PAUSE_CYCLES - 1))) begin
          state_next = ST_FINISH;
          end_next   = END_HANGUP;
        end else if (trigger) begin
          state_next = ST_DISPENSE;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    auth_ready    = 1'b0;
    busy          = 1'b1;
    pump_en       = 1'b0;
    valve_open    = 1'b0;
    dispense_done = 1'b0;
    case (state)
      ST_IDLE: begin
        auth_ready = 1'b1;
        busy       = 1'b0;
      end
      ST_DISPENSE: begin
        pump_en    = 1'b1;
        valve_open = 1'b1;
      end
      ST_PAUSE:  pump_en       = 1'b1;
      ST_FINISH: dispense_done = 1'b1;
      default: ;
    endcase
  end

  // Timer restarts on every state change and idles at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target  <= '0;
      price   <= '0;
      liters  <= '0;
      amount  <= '0;
      timer   <= '0;
      end_reg <= END_FULL;
    end else begin
      end_reg <= end_next;
      if ((state_next != state) || (state == ST_IDLE)) timer <= '0;
      else                                             timer <= timer + TIMER_W'(1);
      if (accept) begin
        target <= auth_liters;
        price  <= auth_price;
        liters <= '0;
        amount <= '0;
      end else if (litre_tick) begin
        liters <= liters + LITER_W'(1);
        amount <= amount + COST_W'(price);
      end
    end
  end

  assign liters_dispensed = liters;
  assign amount_charged   = amount;
  assign end_code         = end_reg;
  assign debug.state      = state;
  assign debug.pulse_cnt  = 8'(pulse_cnt);

endmodule

// File: tb/tb_gas_dispense_ctrl.sv
// Self-checking bench for gas_dispense_ctrl: table-driven sales, random sales
// against a litre/charge reference model, and timeout/reset sequences.
module tb_gas_dispense_ctrl;
  import gas_pump_pkg::*;

  localparam int PPL = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        auth_valid = 1'b0;
  logic [7:0]  auth_liters = '0;
  logic [7:0]  auth_price = '0;
  logic        nozzle_lifted = 1'b0;
  logic        trigger = 1'b0;
  logic        flow_pulse = 1'b0;
  logic        auth_ready, pump_en, valve_open, busy, dispense_done;
  logic [7:0]  liters_dispensed;
  logic [15:0] amount_charged;
  logic [1:0]  end_code;
  debug_t      debug;

  gas_dispense_ctrl #(.PULSES_PER_LITER(PPL), .TIMEOUT_CYCLES(1000), .PAUSE_CYCLES(500)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .auth_valid       (auth_valid),
    .auth_liters      (auth_liters),
    .auth_price       (auth_price),
    .auth_ready       (auth_ready),
    .nozzle_lifted    (nozzle_lifted),
    .trigger          (trigger),
    .flow_pulse       (flow_pulse),
    .pump_en          (pump_en),
    .valve_open       (valve_open),
    .liters_dispensed (liters_dispensed),
    .amount_charged   (amount_charged),
    .busy             (busy),
    .dispense_done    (dispense_done),
    .end_code         (end_code),
    .debug            (debug)
  );

  always #5 clk = ~clk;

  typedef struct {
    int target; int price; int n1; int np; int n2;
    bit do_pause; bit hang; bit hwp; bit spurious;
    int exp_l; int exp_c; int exp_code;
  } vec_t;

  vec_t        vecs[8];
  logic [25:0] exp_q[$];
  int          checks = 0, errors = 0;
  int          done_cnt = 0, sale_cnt = 0;
  int          counted_g = 0, full_g = 0;
  logic        prev_done = 1'b0, pump_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [25:0] pack(input int l, input int c, input int code);
    return {8'(l), 16'(c), 2'(code)};
  endfunction

  // Only pulses delivered while actually dispensing count; partial litres are dropped.
  function automatic logic [25:0] ref_model(input int target, input int price, input int total);
    int l;
    if (target == 0) return pack(0, 0, 3);
    if (total >= target * PPL) return pack(target, target * price, 0);
    l = total / PPL;
    return pack(l, l * price, 1);
  endfunction

  always @(negedge clk) begin
    logic [25:0] e;
    if (pump_en) pump_seen = 1'b1;
    if (reset_n && dispense_done) begin
      done_cnt++;
      check("done_single_cycle", 32'(prev_done), 0);
      if (exp_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sale_liters", 32'(liters_dispensed), 32'(e[25:18]));
        check("sale_charged", 32'(amount_charged), 32'(e[17:2]));
        check("sale_end_code", 32'(end_code), 32'(e[1:0]));
      end
    end
    prev_done = dispense_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic phase(input int n, input bit counting, input bit drop_last, input bit spurious);
    for (int i = 0; i < n; i++) begin
      flow_pulse = 1'b1;
      if (drop_last && i == n - 1) begin
        nozzle_lifted = 1'b0;
        trigger = 1'b0;
      end
      if (spurious && i == 0) begin
        auth_valid = 1'b1;
        auth_liters = 8'd99;
        auth_price = 8'd99;
      end
      tick();
      flow_pulse = 1'b0;
      auth_valid = 1'b0;
      if (counting) begin
        counted_g++;
        if (counted_g == full_g) begin
          check("full_stop_pump", 32'(pump_en), 0);
          check("full_stop_valve", 32'(valve_open), 0);
          check("full_stop_done", 32'(dispense_done), 1);
        end
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt != sale_cnt && k < budget) begin
      tick();
      k++;
    end
    if (done_cnt != sale_cnt) check("done_timeout", 32'(done_cnt), 32'(sale_cnt));
  endtask

  task automatic run_sale(input vec_t v, input logic [25:0] exp);
    full_g = v.target * PPL;
    counted_g = 0;
    pump_seen = 1'b0;
    sale_cnt++;
    exp_q.push_back(exp);
    auth_liters = 8'(v.target);
    auth_price = 8'(v.price);
    auth_valid = 1'b1;
    tick();
    auth_valid = 1'b0;
    check("busy_after_auth", 32'(busy), 1);
    check("ready_after_auth", 32'(auth_ready), 0);
    if (v.target == 0) begin
      check("zero_done_now", 32'(dispense_done), 1);
    end else begin
      nozzle_lifted = 1'b1;
      trigger = 1'b1;
      tick();
      check("state_dispense", 32'(debug.state), 32'(ST_DISPENSE));
      phase(v.n1, 1'b1, v.hang && v.hwp && !v.do_pause, v.spurious);
      if (v.do_pause) begin
        trigger = 1'b0;
        tick();
        phase(v.np, 1'b0, 1'b0, 1'b0);
        trigger = 1'b1;
        tick();
        phase(v.n2, 1'b1, v.hang && v.hwp, 1'b0);
      end
      if (v.hang) begin
        nozzle_lifted = 1'b0;
        trigger = 1'b0;
        tick();
      end
    end
    wait_done(400);
    nozzle_lifted = 1'b0;
    trigger = 1'b0;
    tick();
    tick();
    check("ready_idle", 32'(auth_ready), 1);
    check("busy_idle", 32'(busy), 0);
    check("hold_liters", 32'(liters_dispensed), 32'(exp[25:18]));
    check("hold_charged", 32'(amount_charged), 32'(exp[17:2]));
    check("hold_end_code", 32'(end_code), 32'(exp[1:0]));
    if (v.target == 0) check("zero_pump_never_on", 32'(pump_seen), 0);
  endtask

  initial begin
    vec_t v;
    int   k, t, p, total;

    vecs[0] = '{40, 3, 400, 0, 0, 0, 0, 0, 0, 40, 120, 0};
    vecs[1] = '{20, 5, 95, 0, 0, 0, 1, 0, 0, 9, 45, 1};
    vecs[2] = '{0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    vecs[3] = '{5, 4, 25, 20, 25, 1, 0, 0, 1, 5, 20, 0};
    vecs[4] = '{255, 255, 2550, 0, 0, 0, 0, 0, 0, 255, 65025, 0};
    vecs[5] = '{1, 1, 9, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    vecs[6] = '{2, 10, 12, 3, 3, 1, 1, 1, 0, 1, 10, 1};
    vecs[7] = '{3, 6, 20, 0, 0, 0, 1, 1, 0, 2, 12, 1};

    repeat (3) tick();
    check("rst_auth_ready", 32'(auth_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_pump", 32'(pump_en), 0);
    check("rst_valve", 32'(valve_open), 0);
    check("rst_liters", 32'(liters_dispensed), 0);
    check("rst_charged", 32'(amount_charged), 0);
    check("rst_end_code", 32'(end_code), 0);
    check("rst_done", 32'(dispense_done), 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_sale(vecs[i], pack(vecs[i].exp_l, vecs[i].exp_c, vecs[i].exp_code));

    // Nozzle lifted but trigger never squeezed: the arming timeout still applies.
    pump_seen = 1'b0;
    sale_cnt++;
    exp_q.push_back(pack(0, 0, 2));
    auth_liters = 8'd10;
    auth_price = 8'd2;
    auth_valid = 1'b1;
    tick();
    auth_valid = 1'b0;
    nozzle_lifted = 1'b1;
    k = 0;
    while (!dispense_done && k < 1100) begin
      tick();
      k++;
    end
    check("timeout_latency", 32'(k), 1000);
    nozzle_lifted = 1'b0;
    wait_done(5);
    tick();
    check("timeout_pump_never_on", 32'(pump_seen), 0);

    // Reset in the middle of a delivery.
    full_g = 300;
    counted_g = 0;
    auth_liters = 8'd30;
    auth_price = 8'd2;
    auth_valid = 1'b1;
    tick();
    auth_valid = 1'b0;
    nozzle_lifted = 1'b1;
    trigger = 1'b1;
    tick();
    phase(35, 1'b1, 1'b0, 1'b0);
    check("pre_reset_pump", 32'(pump_en), 1);
    check("pre_reset_liters", 32'(liters_dispensed), 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_pump", 32'(pump_en), 0);
    check("midrst_valve", 32'(valve_open), 0);
    check("midrst_ready", 32'(auth_ready), 1);
    check("midrst_liters", 32'(liters_dispensed), 0);
    check("midrst_charged", 32'(amount_charged), 0);
    check("midrst_end_code", 32'(end_code), 0);
    nozzle_lifted = 1'b0;
    trigger = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      t = $urandom_range(1, 12);
      p = $urandom_range(0, 255);
      v = '{t, p, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      v.hang = ($urandom_range(0, 1) == 1);
      total = v.hang ? $urandom_range(0, t * PPL - 1) : t * PPL;
      v.do_pause = ($urandom_range(0, 1) == 1);
      v.hwp = v.hang && (total > 0) && ($urandom_range(0, 1) == 1);
      if (v.do_pause) begin
        v.n2 = (total > 0) ? $urandom_range(1, total) : 0;
        v.n1 = total - v.n2;
        v.np = $urandom_range(0, 5);
      end else begin
        v.n1 = total;
      end
      run_sale(v, ref_model(t, p, total));
    end

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
